text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
Writer side of the text display path. Accepts a byte stream (valid/ready), interprets control codes, and writes character codes into an on-chip COLS x ROWS character RAM at a hardware cursor. Exposes a pixel-indexed read port that returns the character code under (pos_x, pos_y). That code feeds the font renderer's character input.

Parameters:
- COLS, 80, characters per row (8 px wide each).
- ROWS, 60, character rows (8 px tall each).
- FILL_CHAR, 8'h20, code written by every clear operation.

Ports:
- px_clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_data  in  8  byte to write or interpret.
- in_ready  out  1  writer can accept a byte this cycle.
- pos_x  in  10  screen X in pixels.
- pos_y  in  10  screen Y in pixels.
- character  out  8  registered character code at (pos_x, pos_y).
- cursor_col  out  7  current cursor column, 0..COLS-1.
- cursor_row  out  6  current cursor row, 0..ROWS-1.
- busy  out  1  a clear operation is in progress.

Behaviour:
- Reset values:
  - character=FILL_CHAR, cursor_col=0, cursor_row=0, in_ready=0, busy=1.
  - State=INIT_CLEAR, clear index=0.
- Handshake:
  - A byte transfers when in_valid && in_ready.
  - in_ready = (state==IDLE), registered; it does not depend on in_valid.
- States:
  - INIT_CLEAR: writes FILL_CHAR to all COLS*ROWS cells, one per cycle, then goes to IDLE.
  - IDLE: accepts bytes.
  - CLEAR_LINE: writes FILL_CHAR to the COLS cells of cursor_row, then goes to IDLE.
  - CLEAR_ALL: same as INIT_CLEAR, then goes to IDLE.
  - busy=1 in every state except IDLE.
- Accepted byte, by value:
  - 0x0D (CR): cursor_col=0.
  - 0x0A (LF): cursor_col=0, then new-row advance (below).
  - 0x08 (BS): if cursor_col>0, cursor_col-1 and FILL_CHAR written at the new position in the same cycle. At col 0 it is a no-op.
  - 0x0C (FF): cursor set to (0,0), then CLEAR_ALL.
  - 0x00-0x1F, other values: ignored; cursor unchanged.
  - 0x20-0xFF (printable): written to the cell at the cursor in the acceptance cycle; then cursor_col+1. If cursor_col was COLS-1, cursor_col=0 followed by new-row advance.
- New-row advance:
  - cursor_row+1, wrapping from ROWS-1 to 0.
  - Then enter CLEAR_LINE for the new row. in_ready is low for exactly COLS cycles.
- RAM address = row*COLS+col.
- Read port:
  - col=pos_x[9:3], row=pos_y[9:3].
  - character is registered, 1-cycle latency.
  - If col>=COLS or row>=ROWS, character=FILL_CHAR.
  - Same-cycle read and write to one cell returns the old value (read-before-write).
- Reset asserted in any state restarts INIT_CLEAR; cells partially written beforehand are overwritten.

Optional Feature:
- Macro: TEXT_CONSOLE_SCROLL_EN.
- With it defined:
  - A register top_row (6 bits, reset 0) is maintained.
  - On new-row advance from row ROWS-1, cursor_row stays ROWS-1 and top_row increments mod ROWS.
  - The line cleared is the physical row (top_row_new+ROWS-1) mod ROWS.
  - The read port maps screen row r to physical row (r+top_row) mod ROWS.
  - FF resets top_row to 0.
- Without it: cursor wraps to row 0, top_row logic is absent, and reads are unmapped.

Decomposition:
- Package console_pkg holds:
  - Control-code constants: CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D.
  - State enum: INIT_CLEAR, IDLE, CLEAR_LINE, CLEAR_ALL.
- Sub-module char_ram: simple dual-port RAM, 1 sync write port, 1 registered read port, depth COLS*ROWS, no reset.

Test Plan:
1. Reset, hold in_valid=1 -> busy=1 and in_ready=0 for 4800 cycles. Afterwards, every in-range (pos_x,pos_y) reads 0x20.
2. Send 0x41 once idle -> pos (0,0) reads 0x41 one cycle after being presented; cursor=(1,0); (8,0) reads 0x20.
3. Send 80 × 0x42 from (0,0) -> cursor=(0,1), in_ready low exactly 80 cycles, row 1 reads 0x20, row 0 all 0x42.
4. Send 0x43 then 0x08 ×2 -> cell (0,0) reads 0x20, cursor (0,0); the second BS is a no-op.
5. Cursor at row 59, send 0x0A:
   - Without the macro: cursor (0,0) and row 0 cleared.
   - With TEXT_CONSOLE_SCROLL_EN: cursor (0,59), screen row 0 shows old row 1, screen row 59 reads 0x20.
6. Assert rst mid-CLEAR_LINE, then send 0x0C after recovery -> INIT_CLEAR restarts with 4800 busy cycles; FF gives cursor (0,0) plus a 4800-cycle clear.

Source files
------------

// File: rtl/console_pkg.sv
// console_pkg: shared definitions for the text console writer.
//   - default geometry and fill code (COLS x ROWS cells, 8x8 px each)
//   - control-code byte values interpreted by the writer
//   - writer FSM state type
//   - map_row(): (r + top) mod rows, used by the scroll option
package console_pkg;

  localparam int         DEF_COLS      = 80;
  localparam int         DEF_ROWS      = 60;
  localparam logic [7:0] DEF_FILL_CHAR = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    CLEAR_LINE = 2'd2,
    CLEAR_ALL  = 2'd3
  } state_t;

  // Both operands are below rows, so one conditional subtract is enough.
  function automatic logic [5:0] map_row(input logic [5:0] r, input logic [5:0] top,
                                         input int rows);
    logic [6:0] sum;
    sum = {1'b0, r} + {1'b0, top};
    if (sum >= 7'(rows)) sum = sum - 7'(rows);
    return sum[5:0];
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// text_console_writer_if: byte stream into the console writer.
//   in_valid : source has a byte on in_data
//   in_data  : byte to print or interpret
//   in_ready : writer accepts a byte this cycle
// Handshake: a byte moves on a rising clock edge where in_valid && in_ready.
// in_ready never depends on in_valid; the source holds in_data stable while
// in_valid is high and the byte has not yet transferred.
// Modports: master = byte source, slave = writer.
interface text_console_writer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/char_ram.sv
// char_ram: simple dual-port character RAM, no reset.
//   clk   : clock
//   we    : write enable; wdata lands at waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : registered read data, one cycle after raddr
// A read and a write to the same address in one cycle return the old value.
module char_ram #(
  parameter int DEPTH = 4800,
  parameter int AW    = 13,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: writer side of the text display path.
// Takes a byte stream, interprets CR/LF/BS/FF, writes printable codes into a
// COLS x ROWS character RAM at a hardware cursor, and serves a pixel-indexed
// read port for the font renderer.
// Ports:
//   px_clk     : pixel clock, all logic on the rising edge
//   rst        : synchronous, active-high reset
//   in_if      : byte stream (slave side of text_console_writer_if)
//   pos_x/y    : screen pixel position to read
//   character  : code under (pos_x, pos_y), one cycle latency
//   cursor_col : cursor column 0..COLS-1
//   cursor_row : cursor row 0..ROWS-1
//   busy       : a clear sweep is running
//   state      : FSM state (debug)
// Optional: define TEXT_CONSOLE_SCROLL_EN to scroll instead of wrapping to
// row 0 when a new row is needed past the bottom row.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS      = DEF_COLS,
  parameter int         ROWS      = DEF_ROWS,
  parameter logic [7:0] FILL_CHAR = DEF_FILL_CHAR
) (
  input  logic                 px_clk,
  input  logic                 rst,
  text_console_writer_if.slave in_if,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  output logic [7:0]           character,
  output logic [6:0]           cursor_col,
  output logic [5:0]           cursor_row,
  output logic                 busy,
  output state_t               state
);

  localparam int             CELLS     = COLS * ROWS;
  localparam int             AW        = $clog2(CELLS);
  localparam logic [AW-1:0]  LAST_CELL = AW'(CELLS - 1);
  localparam logic [AW-1:0]  LAST_LIDX = AW'(COLS - 1);
  localparam logic [6:0]     LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]     LAST_ROW  = 6'(ROWS - 1);

  function automatic logic [AW-1:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  logic          ready_q;
  logic [AW-1:0] clr_idx;
  logic [5:0]    clr_row;     // physical row swept by CLEAR_LINE

  logic          take;
  logic          is_print;
  logic          adv;         // accepted byte needs a new-row advance
  logic [5:0]    row_adv;     // cursor_row after the advance
  logic [5:0]    phys_cur;    // physical RAM row under the cursor
  logic [5:0]    phys_clr;    // physical RAM row to clear after the advance

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [5:0]    top_row;     // physical row shown on screen row 0
  logic [5:0]    top_adv;
`endif

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [7:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;

  assign in_if.in_ready = ready_q;

  // Byte decode and new-row arithmetic.
  always_comb begin
    take     = in_if.in_valid && ready_q;
    is_print = in_if.in_data >= 8'h20;
    adv      = take && ((in_if.in_data == CC_LF) || (is_print && cursor_col == LAST_COL));
`ifdef TEXT_CONSOLE_SCROLL_EN
    // At the bottom row the cursor stays put and the window moves down one
    // line; the line that becomes the new bottom row is the one cleared.
    if (cursor_row == LAST_ROW) begin
      row_adv = LAST_ROW;
      top_adv = map_row(top_row, 6'd1, ROWS);
    end else begin
      row_adv = cursor_row + 6'd1;
      top_adv = top_row;
    end
    phys_cur = map_row(cursor_row, top_row, ROWS);
    phys_clr = map_row(row_adv, top_adv, ROWS);
`else
    row_adv  = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
    phys_cur = cursor_row;
    phys_clr = row_adv;
`endif
  end

  // RAM write port: clear sweeps, or the accepted byte in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = FILL_CHAR;
    case (state)
      INIT_CLEAR, CLEAR_ALL: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx;
      end
      CLEAR_LINE: begin
        ram_we    = 1'b1;
        ram_waddr = cell_addr(clr_row, 7'd0) + clr_idx;
      end
      IDLE: begin
        if (take) begin
          if (is_print) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(phys_cur, cursor_col);
            ram_wdata = in_if.in_data;
          end else if (in_if.in_data == CC_BS && cursor_col != 7'd0) begin
            ram_we    = 1'b1;
            ram_waddr = cell_addr(phys_cur, cursor_col - 7'd1);
          end
        end
      end
      default: ;
    endcase
  end

  // Writer FSM: state, cursor, clear counter and registered in_ready/busy.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      state      <= INIT_CLEAR;
      clr_idx    <= '0;
      clr_row    <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      ready_q    <= 1'b0;
      busy       <= 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
      top_row    <= '0;
`endif
    end else begin
      case (state)
        INIT_CLEAR, CLEAR_ALL: begin
          if (clr_idx == LAST_CELL) begin
            state   <= IDLE;
            clr_idx <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        CLEAR_LINE: begin
          if (clr_idx == LAST_LIDX) begin
            state   <= IDLE;
            clr_idx <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        IDLE: begin
          if (adv) begin
            // LF, or a printable byte in the last column.
            cursor_col <= '0;
            cursor_row <= row_adv;
            clr_row    <= phys_clr;
            clr_idx    <= '0;
            state      <= CLEAR_LINE;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
            top_row    <= top_adv;
`endif
          end else if (take) begin
            if (is_print) begin
              cursor_col <= cursor_col + 7'd1;
            end else begin
              case (in_if.in_data)
                CC_CR: cursor_col <= '0;
                CC_BS: if (cursor_col != 7'd0) cursor_col <= cursor_col - 7'd1;
                CC_FF: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  clr_idx    <= '0;
                  state      <= CLEAR_ALL;
                  ready_q    <= 1'b0;
                  busy       <= 1'b1;
`ifdef TEXT_CONSOLE_SCROLL_EN
                  top_row    <= '0;
`endif
                end
                default: ;
              endcase
            end
          end
        end
        default: state <= INIT_CLEAR;
      endcase
    end
  end

  // Read port: pixel position to cell; off-screen cells read as FILL_CHAR.
  logic [6:0] rd_col;
  logic [6:0] rd_row;
  logic [5:0] rd_phys;
  logic       rd_oob;
  logic       oob_q;
  logic       unused_bits;

  assign unused_bits = ^{pos_x[2:0], pos_y[2:0]};

  always_comb begin
    rd_col = pos_x[9:3];
    rd_row = pos_y[9:3];
    rd_oob = (rd_col >= 7'(COLS)) || (rd_row >= 7'(ROWS));
`ifdef TEXT_CONSOLE_SCROLL_EN
    rd_phys = map_row(rd_row[5:0], top_row, ROWS);
`else
    rd_phys = rd_row[5:0];
`endif
    ram_raddr = rd_oob ? '0 : cell_addr(rd_phys, rd_col);
  end

  // The RAM has no reset, so the off-screen flag (set in reset) supplies
  // the FILL_CHAR reset value of character.
  always_ff @(posedge px_clk) begin
    if (rst) oob_q <= 1'b1;
    else     oob_q <= rd_oob;
  end

  assign character = oob_q ? FILL_CHAR : ram_rdata;

  char_ram #(
    .DEPTH (CELLS),
    .AW    (AW),
    .DW    (8)
  ) u_char_ram (
    .clk   (px_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_text_console_writer.sv
// Testbench for text_console_writer: directed sequence with a read-port
// scoreboard (expected codes queued when a position is presented, popped
// when the registered character appears one cycle later).
module tb_text_console_writer;
  import console_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] character;
  logic [6:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;
  state_t     state;

  text_console_writer_if bus ();

  text_console_writer dut (
    .px_clk     (clk),
    .rst        (rst),
    .in_if      (bus),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .character  (character),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy),
    .state      (state)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  // Scoreboard / comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cursor(input string tag, input int col, input int row);
    check({tag, "_col"}, {25'd0, cursor_col}, 32'(col));
    check({tag, "_row"}, {26'd0, cursor_row}, 32'(row));
  endtask

  // Present a cell on the read port; compare the code one cycle later.
  task automatic read_cell(input int col, input int row, input logic [7:0] exp,
                           input string tag);
    logic [7:0] e;
    @(negedge clk);
    pos_x = 10'(col * 8 + int'($urandom_range(0, 7)));
    pos_y = 10'(row * 8 + int'($urandom_range(0, 7)));
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {24'd0, character}, {24'd0, e});
  endtask

  // Driver: wait (bounded) for in_ready, then hold the byte for one edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count cycles with busy high (bounded); ends on the first idle negedge.
  task automatic count_busy(output int n, output int ready_seen);
    n = 0;
    ready_seen = 0;
    while (busy === 1'b1 && n < 10000) begin
      if (bus.in_ready !== 1'b0) ready_seen++;
      n++;
      @(negedge clk);
    end
  endtask

  int n_busy;
  int n_rdy;
  int bad_cells;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    pos_x        = '0;
    pos_y        = '0;
    repeat (3) @(negedge clk);

    // 1. reset values, then 4800-cycle initial clear with in_valid held
    check("rst_character", {24'd0, character}, 32'h20);
    check_cursor("rst_cursor", 0, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_state", {30'd0, state}, {30'd0, INIT_CLEAR});
    rst = 1'b0;
    count_busy(n_busy, n_rdy);
    bus.in_valid = 1'b0;
    check("init_busy_cycles", 32'(n_busy), 32'd4800);
    check("init_ready_while_busy", 32'(n_rdy), 32'd0);
    check("init_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("init_state_idle", {30'd0, state}, {30'd0, IDLE});
    bad_cells = 0;
    for (int r = 0; r < 60; r++)
      for (int c = 0; c < 80; c++)
        read_cell(c, r, 8'h20, "init_cell_fill");
    check_cursor("init_cursor", 0, 0);

    // 2. single printable byte
    send_byte(8'h41);
    check_cursor("a_cursor", 1, 0);
    read_cell(0, 0, 8'h41, "a_cell00");
    read_cell(1, 0, 8'h20, "a_cell10");

    // 3. full row of 0x42 from column 0
    send_byte(CC_CR);
    check_cursor("cr_cursor", 0, 0);
    for (int i = 0; i < 80; i++) send_byte(8'h42);
    check_cursor("row_wrap_cursor", 0, 1);
    count_busy(n_busy, n_rdy);
    check("line_clear_cycles", 32'(n_busy), 32'd80);
    for (int c = 0; c < 80; c++) read_cell(c, 0, 8'h42, "row0_b");
    for (int c = 0; c < 80; c++) read_cell(c, 1, 8'h20, "row1_clear");

    // 4. printable then two backspaces; the second is a no-op at column 0
    send_byte(8'h43);
    read_cell(0, 1, 8'h43, "bs_pre_cell");
    check_cursor("bs_pre_cursor", 1, 1);
    send_byte(CC_BS);
    check_cursor("bs1_cursor", 0, 1);
    send_byte(CC_BS);
    check_cursor("bs2_cursor", 0, 1);
    read_cell(0, 1, 8'h20, "bs_cell_cleared");
    read_cell(79, 0, 8'h42, "bs_row0_intact");

    // ignored control code and off-screen reads
    send_byte(8'h07);
    check_cursor("ctl_ignored_cursor", 0, 1);
    for (int i = 0; i < 30; i++) send_byte(8'h44);
    check_cursor("d_cursor", 30, 1);
    read_cell(20, 1, 8'h44, "d_cell");
    read_cell(100, 0, 8'h20, "oob_col");
    read_cell(5, 60, 8'h20, "oob_row");

    // 5. walk the cursor to the bottom row and advance past it
    send_byte(CC_LF);
    count_busy(n_busy, n_rdy);
    check("lf_clear_cycles", 32'(n_busy), 32'd80);
    check_cursor("lf_cursor", 0, 2);
    for (int i = 0; i < 57; i++) send_byte(CC_LF);
    check_cursor("bottom_cursor", 0, 59);
    send_byte(8'h45);
    send_byte(CC_LF);
    count_busy(n_busy, n_rdy);
    check("bottom_lf_cycles", 32'(n_busy), 32'd80);
`ifdef TEXT_CONSOLE_SCROLL_EN
    check_cursor("scroll_cursor", 0, 59);
    read_cell(0, 0, 8'h44, "scroll_row0_old_row1");
    read_cell(29, 0, 8'h44, "scroll_row0_col29");
    read_cell(0, 59, 8'h20, "scroll_row59_clear");
    read_cell(79, 59, 8'h20, "scroll_row59_col79");
    read_cell(0, 58, 8'h45, "scroll_row58_old_row59");
    send_byte(8'h46);
    read_cell(0, 59, 8'h46, "scroll_write_bottom");
`else
    check_cursor("wrap_cursor", 0, 0);
    read_cell(0, 0, 8'h20, "wrap_row0_clear");
    read_cell(79, 0, 8'h20, "wrap_row0_col79");
    read_cell(0, 1, 8'h44, "wrap_row1_kept");
    read_cell(0, 59, 8'h45, "wrap_row59_kept");
    send_byte(8'h46);
    read_cell(0, 0, 8'h46, "wrap_write_top");
`endif

    // 6. reset in the middle of a line clear, then form feed
    send_byte(CC_LF);
    repeat (10) @(negedge clk);
    check("mid_state_clear_line", {30'd0, state}, {30'd0, CLEAR_LINE});
    rst = 1'b1;
    @(negedge clk);
    check("rst2_state", {30'd0, state}, {30'd0, INIT_CLEAR});
    check("rst2_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    count_busy(n_busy, n_rdy);
    check("rst2_busy_cycles", 32'(n_busy), 32'd4800);
    check("rst2_ready_while_busy", 32'(n_rdy), 32'd0);
    check_cursor("rst2_cursor", 0, 0);
    read_cell(0, 0, 8'h20, "rst2_cell00");
    read_cell(20, 1, 8'h20, "rst2_cell_row1");
    read_cell(0, 58, 8'h20, "rst2_cell_row58");
    read_cell(0, 59, 8'h20, "rst2_cell_row59");

    send_byte(8'h47);
    send_byte(CC_LF);
    send_byte(CC_LF);
    send_byte(8'h48);
    check_cursor("pre_ff_cursor", 1, 2);
    read_cell(0, 2, 8'h48, "pre_ff_cell");
    send_byte(CC_FF);
    check_cursor("ff_cursor", 0, 0);
    check("ff_state", {30'd0, state}, {30'd0, CLEAR_ALL});
    count_busy(n_busy, n_rdy);
    check("ff_busy_cycles", 32'(n_busy), 32'd4800);
    check("ff_ready_while_busy", 32'(n_rdy), 32'd0);
    read_cell(0, 0, 8'h20, "ff_cell00");
    read_cell(0, 2, 8'h20, "ff_cell02");
    send_byte(8'h49);
    read_cell(0, 0, 8'h49, "post_ff_write");
    check_cursor("post_ff_cursor", 1, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
